echo_detector: RTL and testbench

- Downstream consumer of the filter bank's moving-average output (Y_maf).
- Treats the MAF output as the echo envelope, one sample per filter frame.
- After each ping it applies a blanking window, then looks for CONFIRM consecutive envelope samples at or above a threshold.
- Reports time-of-flight in samples, peak envelope and timeout status to the register/IRQ layer.

---
 rtl/echo_detector_if.sv | 29 ++
 rtl/echo_detector.sv | 139 +++++++++++++
 tb/tb_echo_detector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/echo_detector_if.sv
// Port bundle between the echo detector and its register/IRQ layer.
// master drives measurement control and envelope samples; slave is the detector.
interface echo_detector_if #(
  parameter int N  = 16,
  parameter int CW = 16
);
  logic          start;
  logic          sample_valid;
  logic [N-1:0]  env_in;
  logic [N-1:0]  threshold;
  logic [CW-1:0] blank_samples;
  logic [CW-1:0] max_samples;
  logic          busy;
  logic          done;
  logic          echo_found;
  logic          timeout;
  logic [CW-1:0] tof;
  logic [N-1:0]  peak;

  modport master (
    output start, sample_valid, env_in, threshold, blank_samples, max_samples,
    input  busy, done, echo_found, timeout, tof, peak
  );

  modport slave (
    input  start, sample_valid, env_in, threshold, blank_samples, max_samples,
    output busy, done, echo_found, timeout, tof, peak
  );
endinterface

// File: rtl/echo_detector.sv
// Echo detector: after a ping, blank the first samples of the MAF envelope, then
// look for CONFIRM consecutive samples at/above threshold; report tof, peak, timeout.
//
//   state | meaning
//   IDLE  | waiting for start; results of the last measurement held
//   ARMED | counting sample strobes, evaluating samples past the blanking window
//   FIN   | one cycle; done pulses in the cycle after it
module echo_detector #(
  parameter int N       = 16,
  parameter int CW      = 16,
  parameter int CONFIRM = 3
) (
  input  logic            clk,
  input  logic            rst,
  echo_detector_if.slave  bus
);

  localparam int RW = 4;
  localparam logic [RW-1:0] CONF_V   = RW'(CONFIRM);
  localparam logic [RW-1:0] CONF_M1R = RW'(CONFIRM - 1);
  localparam logic [CW-1:0] CONF_M1  = CW'(CONFIRM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [RW-1:0] run_q, run_d;
  logic [N-1:0]  peak_q, peak_d;
  logic [CW-1:0] tof_q, tof_d;
  logic          echo_q, echo_d;
  logic          tmo_q, tmo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          eval;
  logic          hit;
  logic          confirm;
  logic          last;
  logic [CW-1:0] k_inc;
  logic [RW-1:0] run_inc;

  assign eval    = (k_q >= bus.blank_samples);
  assign hit     = (bus.env_in >= bus.threshold);
  assign confirm = eval && hit && (run_q == CONF_M1R);
  // max_samples == 0 means listen forever, so the window end is never matched
  assign last    = (bus.max_samples != '0) && (k_q == bus.max_samples - 1'b1);
  assign k_inc   = (k_q == '1) ? k_q : k_q + 1'b1;
  assign run_inc = (run_q == CONF_V) ? run_q : run_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      run_q   <= '0;
      peak_q  <= '0;
      tof_q   <= '0;
      echo_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      run_q   <= run_d;
      peak_q  <= peak_d;
      tof_q   <= tof_d;
      echo_q  <= echo_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    run_d   = run_q;
    peak_d  = peak_q;
    tof_d   = tof_q;
    echo_d  = echo_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // start wins over everything, including a coincident sample strobe
    if (bus.start) begin
      state_d = ARMED;
      k_d     = '0;
      run_d   = '0;
      peak_d  = '0;
      tof_d   = '0;
      echo_d  = 1'b0;
      tmo_d   = 1'b0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (bus.sample_valid) begin
            k_d = k_inc;
            if (eval) begin
              if (bus.env_in > peak_q) peak_d = bus.env_in;
              run_d = hit ? run_inc : '0;
            end
            // detection on the final window sample beats the timeout
            if (confirm) begin
              tof_d   = k_q - CONF_M1;
              echo_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = FIN;
            end else if (last) begin
              tof_d   = '1;
              tmo_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = FIN;
            end
          end
        end
        FIN: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.echo_found = echo_q;
  assign bus.timeout    = tmo_q;
  assign bus.tof        = tof_q;
  assign bus.peak       = peak_q;

endmodule

// File: tb/tb_echo_detector.sv
// Scoreboard bench for echo_detector: directed scenarios plus random measurements,
// expected results computed from whole envelope sequences by a window-search model.
module tb_echo_detector;
  localparam int N    = 16;
  localparam int CW   = 16;
  localparam int CONF = 3;

  typedef struct {
    bit echo;
    bit tmo;
    int tof;
    int peak;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  echo_detector_if #(.N(N), .CW(CW)) ifc ();

  echo_detector #(.N(N), .CW(CW), .CONFIRM(CONF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: first window of CONF hits wholly past blanking and inside the listen window
  function automatic void model(input int env[$], input int blank, input int maxs,
                                input int thr, output int dec, output exp_t e);
    int  lim;
    bit  found;
    lim   = (maxs == 0) ? env.size() : maxs;
    dec   = -1;
    found = 1'b0;
    e     = '{echo: 1'b0, tmo: 1'b0, tof: 0, peak: 0, done_cyc: 0};
    for (int s = blank; s + CONF - 1 < lim; s++) begin
      bit ok = 1'b1;
      for (int j = 0; j < CONF; j++) if (env[s + j] < thr) ok = 1'b0;
      if (ok && !found) begin
        found  = 1'b1;
        dec    = s + CONF - 1;
        e.echo = 1'b1;
        e.tof  = s;
      end
    end
    if (!found && maxs != 0) begin
      dec   = maxs - 1;
      e.tmo = 1'b1;
      e.tof = 32'hFFFF;
    end
    if (dec >= 0)
      for (int k = blank; k <= dec; k++) if (env[k] > e.peak) e.peak = env[k];
  endfunction

  // Monitor: every done pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (ifc.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc, e.done_cyc);
        chk("echo_found", ifc.echo_found, e.echo);
        chk("timeout", ifc.timeout, e.tmo);
        chk("tof", ifc.tof, e.tof);
        chk("peak", ifc.peak, e.peak);
        chk("busy_in_done", ifc.busy, 0);
      end
    end
  end

  task automatic strobe(input int v);
    repeat ($urandom_range(15, 18)) @(posedge clk);
    #1;
    ifc.sample_valid = 1'b1;
    ifc.env_in       = N'(v);
    @(posedge clk);
    #1;
    ifc.sample_valid = 1'b0;
  endtask

  task automatic run_meas(input int env[$], input int blank, input int maxs, input int thr,
                          input int nlimit, input bit sv_with_start);
    int   dec;
    int   nstr;
    exp_t e;
    model(env, blank, maxs, thr, dec, e);
    ifc.threshold     = N'(thr);
    ifc.blank_samples = CW'(blank);
    ifc.max_samples   = CW'(maxs);
    ifc.start         = 1'b1;
    if (sv_with_start) begin
      ifc.sample_valid = 1'b1;
      ifc.env_in       = 16'hFFFF;
    end
    @(posedge clk);
    #1;
    ifc.start        = 1'b0;
    ifc.sample_valid = 1'b0;
    chk("busy_after_start", ifc.busy, 1);
    nstr = (dec >= 0) ? dec + 1 : env.size();
    if (nstr > nlimit) nstr = nlimit;
    for (int i = 0; i < nstr; i++) begin
      strobe(env[i]);
      if (i == dec) begin
        e.done_cyc = cyc + 1;
        sb.push_back(e);
        chk("flag_echo_pre_done", ifc.echo_found, e.echo);
        chk("flag_tmo_pre_done", ifc.timeout, e.tmo);
        chk("done_early", ifc.done, 0);
        repeat (4) @(negedge clk);
        chk("done_arrived", sb.size(), 0);
        sb.delete();
      end
    end
    if (dec < 0 || dec >= nstr) chk("busy_still_armed", ifc.busy, 1);
  endtask

  initial begin
    int env[$];
    ifc.start         = 1'b0;
    ifc.sample_valid  = 1'b0;
    ifc.env_in        = '0;
    ifc.threshold     = '0;
    ifc.blank_samples = '0;
    ifc.max_samples   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_echo", ifc.echo_found, 0);
    chk("rst_tmo", ifc.timeout, 0);
    chk("rst_tof", ifc.tof, 0);
    chk("rst_peak", ifc.peak, 0);
    rst = 1'b0;

    // basic detect: tof 10, peak 1500
    env = {};
    for (int k = 0; k < 100; k++) env.push_back((k >= 10 && k <= 12) ? 1500 : 200);
    run_meas(env, 4, 100, 1000, 1000, 1'b0);

    // blanking hides the early large samples -> timeout, peak 0
    env = {};
    for (int k = 0; k < 20; k++) env.push_back(k < 4 ? 5000 : 0);
    run_meas(env, 4, 20, 1000, 1000, 1'b0);

    // broken run: hi,hi,lo,hi,hi,hi from k=5 -> tof 8
    env = {};
    for (int k = 0; k < 50; k++)
      env.push_back((k == 5 || k == 6 || (k >= 8 && k <= 10)) ? 2000 : 100);
    run_meas(env, 5, 50, 1000, 1000, 1'b0);

    // confirming run ends on the last window sample -> echo beats timeout
    env = {};
    for (int k = 0; k < 12; k++) env.push_back(k >= 9 ? 3000 : 10);
    run_meas(env, 0, 12, 1000, 1000, 1'b0);

    // blank >= max: nothing evaluated
    env = {};
    for (int k = 0; k < 6; k++) env.push_back(9000);
    run_meas(env, 8, 6, 1000, 1000, 1'b0);

    // abort at k=6, then restart with a coincident (discarded) strobe
    env = {};
    for (int k = 0; k < 40; k++) env.push_back((k >= 8 && k <= 10) ? 4000 : 0);
    run_meas(env, 0, 40, 1000, 7, 1'b0);
    env = {};
    for (int k = 0; k < 40; k++) env.push_back((k >= 3 && k <= 5) ? 2500 : 0);
    run_meas(env, 0, 40, 1000, 1000, 1'b1);

    // reset mid-measurement at k=30, later strobes ignored
    env = {};
    for (int k = 0; k < 31; k++) env.push_back(0);
    run_meas(env, 0, 0, 1000, 1000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", ifc.busy, 0);
    chk("midrst_tof", ifc.tof, 0);
    chk("midrst_peak", ifc.peak, 0);
    chk("midrst_echo", ifc.echo_found, 0);
    for (int i = 0; i < 4; i++) strobe(60000);
    chk("idle_busy", ifc.busy, 0);
    chk("idle_echo", ifc.echo_found, 0);
    chk("idle_peak", ifc.peak, 0);

    // random measurements
    for (int t = 0; t < 20; t++) begin
      int thr, blank, maxs, len;
      thr   = $urandom_range(500, 3000);
      blank = $urandom_range(0, 6);
      maxs  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 30);
      len   = (maxs != 0) ? maxs : 30;
      env   = {};
      for (int k = 0; k < len; k++)
        env.push_back($urandom_range(0, 1) ? thr + $urandom_range(0, 2000)
                                           : $urandom_range(0, thr - 1));
      run_meas(env, blank, maxs, thr, 1000, $urandom_range(0, 3) == 0);
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
